// File: rtl/data_mem_responder.sv
// Memory-side responder for the processor's memread/memwrite data port.
// One request at a time, committed after LATENCY cycles and answered with a one-cycle ready pulse.
module data_mem_responder #(
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 2
) (
    input  logic        clock,
    input  logic        Reset,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [31:0] address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        ready,
    output logic        error,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [3:0] LOAD_COUNT = 4'(LATENCY - 1);

    state_t      r_state;
    logic [3:0]  r_count;
    logic        r_read;
    logic        r_write;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_readdata;
    logic        r_ready;
    logic        r_error;
    logic        r_busy;
    logic [31:0] r_mem [0:(2**ADDR_BITS)-1];

    logic                 w_accept;
    logic                 w_commit;
    logic                 w_useLive;
    logic                 w_read;
    logic                 w_write;
    logic [31:0]          w_addr;
    logic [31:0]          w_wdata;
    logic                 w_bad;
    logic                 w_memWrite;
    logic [ADDR_BITS-1:0] w_index;

    // With LATENCY=1 the commit lands on the acceptance edge, so the live inputs are used.
    assign w_useLive  = (r_state == IDLE);
    assign w_read     = w_useLive ? memread   : r_read;
    assign w_write    = w_useLive ? memwrite  : r_write;
    assign w_addr     = w_useLive ? address   : r_addr;
    assign w_wdata    = w_useLive ? writedata : r_wdata;
    assign w_accept   = (r_state == IDLE) && (memread || memwrite);
    assign w_commit   = Reset && (((LATENCY == 1) && w_accept) ||
                                  ((r_state == BUSY) && (r_count == 4'd1)));
    assign w_bad      = (w_read && w_write) || (|w_addr[1:0]) ||
                        (|(w_addr >> (ADDR_BITS + 2)));
    assign w_index    = w_addr[ADDR_BITS+1:2];
    assign w_memWrite = w_commit && !w_bad && w_write;

    always_ff @(posedge clock) begin
        if (w_memWrite) begin
            r_mem[w_index] <= w_wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (!Reset) begin
            r_state    <= IDLE;
            r_count    <= 4'd0;
            r_read     <= 1'b0;
            r_write    <= 1'b0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_readdata <= 32'd0;
            r_ready    <= 1'b0;
            r_error    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_read  <= memread;
                        r_write <= memwrite;
                        r_addr  <= address;
                        r_wdata <= writedata;
                        r_busy  <= 1'b1;
                        if (LATENCY == 1) begin
                            r_state <= RESP;
                        end else begin
                            r_state <= BUSY;
                            r_count <= LOAD_COUNT;
                        end
                    end
                end
                BUSY: begin
                    r_count <= r_count - 4'd1;
                    if (r_count == 4'd1) begin
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
            // Rejected requests leave both RAM and readdata untouched.
            if (w_commit) begin
                r_ready <= 1'b1;
                r_error <= w_bad;
                if (!w_bad && w_read) begin
                    r_readdata <= r_mem[w_index];
                end
            end
        end
    end

    assign readdata = r_readdata;
    assign ready    = r_ready;
    assign error    = r_error;
    assign busy     = r_busy;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed testbench for data_mem_responder: one instance with LATENCY=2, one with LATENCY=1.
module tb_data_mem_responder;

    logic        clock;
    logic        Reset;
    logic        memread2, memwrite2, memread1, memwrite1;
    logic [31:0] address2, writedata2, address1, writedata1;
    logic [31:0] readdata2, readdata1;
    logic        ready2, error2, busy2, ready1, error1, busy1;

    int checks = 0;
    int errors = 0;

    data_mem_responder #(.ADDR_BITS(8), .LATENCY(2)) u_dut2 (
        .clock(clock), .Reset(Reset), .memread(memread2), .memwrite(memwrite2),
        .address(address2), .writedata(writedata2), .readdata(readdata2),
        .ready(ready2), .error(error2), .busy(busy2)
    );

    data_mem_responder #(.ADDR_BITS(8), .LATENCY(1)) u_dut1 (
        .clock(clock), .Reset(Reset), .memread(memread1), .memwrite(memwrite1),
        .address(address1), .writedata(writedata1), .readdata(readdata1),
        .ready(ready1), .error(error1), .busy(busy1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Issues one request, waits (bounded) for ready, then returns one cycle later in IDLE.
    task automatic xfer(input bit sel, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] data,
                        output logic gotReady, output logic gotErr,
                        output int cycles, output logic [31:0] rdata);
        if (sel) begin
            memread1 = rd; memwrite1 = wr; address1 = addr; writedata1 = data;
        end else begin
            memread2 = rd; memwrite2 = wr; address2 = addr; writedata2 = data;
        end
        cycles   = 0;
        gotReady = 1'b0;
        while (!gotReady && cycles < 20) begin
            @(posedge clock); #1;
            cycles++;
            gotReady = sel ? ready1 : ready2;
        end
        gotErr = sel ? error1 : error2;
        rdata  = sel ? readdata1 : readdata2;
        memread1 = 1'b0; memwrite1 = 1'b0; memread2 = 1'b0; memwrite2 = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        Reset = 1'b1;
        @(posedge clock); #1;
        checks++;
        if (readdata2 !== 32'd0) begin errors++; $display("[TB] FAIL reset_readdata: got %h expected 0", readdata2); end
        checks++;
        if (ready2 !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 0", ready2); end
        checks++;
        if (error2 !== 1'b0) begin errors++; $display("[TB] FAIL reset_error: got %b expected 0", error2); end
        checks++;
        if (busy2 !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy2); end
        checks++;
        if (readdata1 !== 32'd0 || busy1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_dut1: got rd=%h busy=%b expected 0/0", readdata1, busy1); end
    endtask

    task automatic test_store_load();
        logic r, e; int c; logic [31:0] d;
        xfer(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, r, e, c, d);
        checks++;
        if (r !== 1'b1 || c != 2) begin errors++; $display("[TB] FAIL store_latency: got ready=%b cycles=%0d expected 1/2", r, c); end
        checks++;
        if (e !== 1'b0) begin errors++; $display("[TB] FAIL store_error: got %b expected 0", e); end
        checks++;
        if (ready2 !== 1'b0) begin errors++; $display("[TB] FAIL ready_width: got %b expected 0", ready2); end
        xfer(0, 1'b1, 1'b0, 32'h10, 32'h0, r, e, c, d);
        checks++;
        if (r !== 1'b1 || c != 2 || e !== 1'b0) begin errors++; $display("[TB] FAIL load_latency: got ready=%b cycles=%0d err=%b expected 1/2/0", r, c, e); end
        checks++;
        if (d !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL load_data: got %h expected deadbeef", d); end
    endtask

    task automatic test_errors();
        logic r, e; int c; logic [31:0] d;
        xfer(0, 1'b1, 1'b0, 32'h12, 32'h0, r, e, c, d);
        checks++;
        if (r !== 1'b1 || e !== 1'b1) begin errors++; $display("[TB] FAIL misaligned_err: got ready=%b err=%b expected 1/1", r, e); end
        checks++;
        if (d !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL misaligned_hold: got %h expected deadbeef", d); end
        xfer(0, 1'b1, 1'b1, 32'h10, 32'h12345678, r, e, c, d);
        checks++;
        if (r !== 1'b1 || e !== 1'b1) begin errors++; $display("[TB] FAIL conflict_err: got ready=%b err=%b expected 1/1", r, e); end
        xfer(0, 1'b1, 1'b0, 32'h10, 32'h0, r, e, c, d);
        checks++;
        if (e !== 1'b0 || d !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL conflict_ram: got err=%b data=%h expected 0/deadbeef", e, d); end
    endtask

    task automatic test_range();
        logic r, e; int c; logic [31:0] d;
        xfer(0, 1'b1, 1'b0, 32'h400, 32'h0, r, e, c, d);
        checks++;
        if (r !== 1'b1 || e !== 1'b1) begin errors++; $display("[TB] FAIL range_err: got ready=%b err=%b expected 1/1", r, e); end
        xfer(0, 1'b0, 1'b1, 32'h3FC, 32'hCAFEF00D, r, e, c, d);
        xfer(0, 1'b1, 1'b0, 32'h3FC, 32'h0, r, e, c, d);
        checks++;
        if (e !== 1'b0 || d !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL last_word: got err=%b data=%h expected 0/cafef00d", e, d); end
    endtask

    task automatic test_reset_abort();
        logic r, e; int c; logic [31:0] d; int seen;
        xfer(0, 1'b0, 1'b1, 32'h20, 32'h1, r, e, c, d);
        memwrite2 = 1'b1; address2 = 32'h20; writedata2 = 32'h2;
        @(posedge clock); #1;
        checks++;
        if (busy2 !== 1'b1) begin errors++; $display("[TB] FAIL abort_busy: got %b expected 1", busy2); end
        Reset = 1'b0;
        @(posedge clock); #1;
        Reset = 1'b1;
        memwrite2 = 1'b0;
        seen = (ready2 === 1'b1) ? 1 : 0;
        checks++;
        if (busy2 !== 1'b0) begin errors++; $display("[TB] FAIL abort_idle: got busy=%b expected 0", busy2); end
        repeat (4) begin
            @(posedge clock); #1;
            if (ready2 === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("[TB] FAIL abort_ready: got %0d pulses expected 0", seen); end
        xfer(0, 1'b1, 1'b0, 32'h20, 32'h0, r, e, c, d);
        checks++;
        if (e !== 1'b0 || d !== 32'h1) begin errors++; $display("[TB] FAIL abort_ram: got err=%b data=%h expected 0/00000001", e, d); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [3] = '{32'h0, 32'h4, 32'h8};
        logic [31:0] datas [3] = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2};
        int pulseAt [3];
        int pulses;
        logic r, e; int c; logic [31:0] d;
        pulses = 0;
        memwrite1 = 1'b1; address1 = addrs[0]; writedata1 = datas[0];
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(posedge clock); #1;
            if (ready1 === 1'b1) begin
                if (pulses < 3) pulseAt[pulses] = cyc;
                pulses++;
                if (pulses < 3) begin
                    address1 = addrs[pulses]; writedata1 = datas[pulses];
                end else begin
                    memwrite1 = 1'b0;
                end
            end
        end
        checks++;
        if (pulses != 3) begin errors++; $display("[TB] FAIL b2b_count: got %0d expected 3", pulses); end
        if (pulses == 3) begin
            checks++;
            if (pulseAt[0] != 1 || pulseAt[1] != 3 || pulseAt[2] != 5) begin
                errors++;
                $display("[TB] FAIL b2b_spacing: got %0d,%0d,%0d expected 1,3,5", pulseAt[0], pulseAt[1], pulseAt[2]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            xfer(1, 1'b1, 1'b0, addrs[i], 32'h0, r, e, c, d);
            checks++;
            if (c != 1 || e !== 1'b0 || d !== datas[i]) begin
                errors++;
                $display("[TB] FAIL b2b_load%0d: got cycles=%0d err=%b data=%h expected 1/0/%h", i, c, e, d, datas[i]);
            end
        end
    endtask

    initial begin
        Reset = 1'b1;
        memread2 = 1'b0; memwrite2 = 1'b0; address2 = 32'd0; writedata2 = 32'd0;
        memread1 = 1'b0; memwrite1 = 1'b0; address1 = 32'd0; writedata1 = 32'd0;
        @(posedge clock); #1;
        test_reset();
        test_store_load();
        test_errors();
        test_range();
        test_reset_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
